// File: rtl/mac_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accumulator_pkg
//  Purpose  : Shared definitions for the MAC accumulate stage: default data
//             width, FSM state encoding and the 16-bit saturation limits.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mac_accumulator_pkg;

    localparam int          c_WIDTH   = 16;
    localparam logic [15:0] c_SAT_MAX = 16'h7FFF;
    localparam logic [15:0] c_SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mac_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accumulator_if
//  Purpose  : Handshake bundle between the multiplier (product stream in),
//             the accumulator, and the downstream result consumer.
//  Ports    : start, in_valid, product, out_ready   driven by the master
//             in_ready, out_valid, sum, overflow, busy driven by the slave
//  Modports : master (stimulus / upstream+downstream side), slave (accumulator)
//  Revision : 1.0  initial release
// ============================================================================
interface mac_accumulator_if
    import mac_accumulator_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] product;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic             busy;

    modport master (
        output start, in_valid, product, out_ready,
        input  in_ready, out_valid, sum, overflow, busy
    );

    modport slave (
        input  start, in_valid, product, out_ready,
        output in_ready, out_valid, sum, overflow, busy
    );

endinterface
`default_nettype wire

// File: rtl/mac_accumulator_signed_add_ovf.sv
`default_nettype none
// ============================================================================
//  Module   : signed_add_ovf
//  Purpose  : WIDTH-bit two's-complement adder with signed-overflow detect.
//             With MAC_ACCUMULATOR_SATURATE_EN defined the result is clamped
//             to the most positive / most negative value on overflow;
//             otherwise it wraps.
//  Ports    : i_a, i_b  operands
//             o_sum     result (wrapped or clamped)
//             o_ovf     signed overflow occurred on this addition
//  Macro    : MAC_ACCUMULATOR_SATURATE_EN
//  Revision : 1.0  initial release
// ============================================================================
module signed_add_ovf #(
    parameter int WIDTH = 16
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_ovf
);

    logic [WIDTH-1:0] w_raw;
    logic             w_ovf;

    assign w_raw = i_a + i_b;

    // Overflow only possible when both operands share a sign; it shows up
    // as the result sign disagreeing with that common sign.
    assign w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_raw[WIDTH-1] != i_a[WIDTH-1]);

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam logic [WIDTH-1:0] c_POS_CLAMP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_NEG_CLAMP = {1'b1, {(WIDTH-1){1'b0}}};

    // On overflow the operand sign tells the direction of the excursion.
    assign o_sum = w_ovf ? (i_a[WIDTH-1] ? c_NEG_CLAMP : c_POS_CLAMP) : w_raw;
`else
    assign o_sum = w_raw;
`endif

    assign o_ovf = w_ovf;

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accumulator
//  Purpose  : Sums exactly N_TERMS signed products received over a
//             valid/ready stream and hands the sum plus a sticky overflow
//             flag to the next stage over a valid/ready handshake.
//  Ports    : clk   rising-edge clock
//             rst   synchronous active-high reset
//             bus   mac_accumulator_if.slave:
//                     start (in), in_valid (in), in_ready (out), product (in),
//                     out_valid (out), out_ready (in), sum (out),
//                     overflow (out), busy (out)
//  Macro    : MAC_ACCUMULATOR_SATURATE_EN (clamp instead of wrap; see adder)
//  Revision : 1.0  initial release
// ============================================================================
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int WIDTH   = c_WIDTH,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mac_accumulator_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(N_TERMS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic [WIDTH-1:0] w_add_sum;
    logic             w_add_ovf;
    logic             w_accept;

    signed_add_ovf #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (bus.product),
        .o_sum (w_add_sum),
        .o_ovf (w_add_ovf)
    );

    assign w_accept = (r_state == ST_ACCUM) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            ST_IDLE: begin
                // Previous result stays visible until a new operation starts.
                if (bus.start) begin
                    w_state_nxt = ST_ACCUM;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt = w_add_sum;
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_ovf_nxt = r_ovf | w_add_ovf;
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here: a new operation
                // needs a start seen while already in IDLE.
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
    assign bus.sum       = r_acc;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_accumulator
//  Purpose  : Self-checking bench for mac_accumulator. Expected results come
//             from an integer-arithmetic reference model and are queued when
//             an operation is issued; a monitor pops them on each result
//             handshake. A second instance built with N_TERMS=1 is exercised
//             directly.
//  Ports    : none
//  Macro    : MAC_ACCUMULATOR_SATURATE_EN selects the clamping model
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_accumulator;
    import mac_accumulator_pkg::*;

    localparam int WIDTH = 16;
    localparam int N     = 8;
    localparam int CNT_W = 4;

    typedef logic [15:0] term_q_t[$];
    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_accumulator_if #(.WIDTH(WIDTH)) bus  ();
    mac_accumulator_if #(.WIDTH(WIDTH)) bus1 ();

    mac_accumulator #(
        .WIDTH   (WIDTH),
        .N_TERMS (N),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mac_accumulator #(
        .WIDTH   (WIDTH),
        .N_TERMS (1),
        .CNT_W   (1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum, with overflow judged against the signed
    // 16-bit range after every term.
    function automatic res_t model(input term_q_t terms);
        int   acc;
        int   t;
        int   clamp;
        res_t r;
        acc   = 0;
        r.ovf = 1'b0;
        foreach (terms[i]) begin
            t = acc + int'($signed(terms[i]));
            if (t > 32767 || t < -32768) begin
                r.ovf = 1'b1;
                clamp = (t > 0) ? int'($signed(c_SAT_MAX)) : int'($signed(c_SAT_MIN));
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                t = clamp;
`else
                t = (t > 32767) ? t - 65536 : t + 65536;
                if (clamp == 0) t = 0;
`endif
            end
            acc = t;
        end
        r.sum = acc[15:0];
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_valid_exclusive", {31'b0, bus.in_ready & bus.out_valid}, 32'd0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_result: sum 0x%0h with no operation pending", bus.sum);
                end else begin
                    check("sum", {16'b0, bus.sum}, {16'b0, exp_q[0].sum});
                    check("overflow", {31'b0, bus.overflow}, {31'b0, exp_q[0].ovf});
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // gap_mode: 0 back-to-back, 1 one idle cycle before each term, 2 random gaps
    task automatic run_op(input term_q_t terms, input int gap_mode, input int hold,
                          input bit start_in_hold, input bit start_at_release);
        res_t e;
        int   gap;
        int   guard;
        e = model(terms);
        exp_q.push_back(e);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        foreach (terms[i]) begin
            gap = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.product  = terms[i];
            guard = 0;
            @(negedge clk);
            while (!bus.in_ready && guard < 20) begin
                guard++;
                @(negedge clk);
            end
            if (!bus.in_ready) begin
                check("in_ready_timeout", 32'd0, 32'd1);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            bus.product  = 16'($urandom);
        end
        @(negedge clk);
        check("latency_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("done_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("done_busy", {31'b0, bus.busy}, 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1 bus.start = start_in_hold & ~bus.start;
        end
        @(posedge clk); #1;
        bus.start     = start_at_release;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("idle_busy", {31'b0, bus.busy}, 32'd0);
        check("idle_sum_held", {16'b0, bus.sum}, {16'b0, e.sum});
        check("idle_ovf_held", {31'b0, bus.overflow}, {31'b0, e.ovf});
    endtask

    initial begin
        term_q_t t;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.product   = '0;
        bus.out_ready = 1'b0;
        bus1.start     = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.product   = '0;
        bus1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_sum", {16'b0, bus.sum}, 32'd0);
        check("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        #1 rst = 1'b0;

        // Products 1..8 back-to-back
        t = {};
        for (int i = 1; i <= 8; i++) t.push_back(16'(i));
        run_op(t, 0, 0, 1'b0, 1'b0);

        // Eight -3 terms
        t = {};
        repeat (8) t.push_back(16'hFFFD);
        run_op(t, 0, 0, 1'b0, 1'b0);

        // Positive overflow
        t = {16'h4000, 16'h4000};
        repeat (6) t.push_back(16'h0000);
        run_op(t, 0, 1, 1'b0, 1'b0);

        // Overflow then a term that brings the value back: flag must stay set
        t = {16'h7000, 16'h7000, 16'h2000};
        repeat (5) t.push_back(16'h0000);
        run_op(t, 0, 0, 1'b0, 1'b0);

        // Negative overflow
        t = {16'h8000, 16'hFFFF, 16'h0005};
        repeat (5) t.push_back(16'h0001);
        run_op(t, 2, 0, 1'b0, 1'b0);

        // Alternating in_valid, result held 5 cycles with start pulses,
        // start raised on the DONE->IDLE edge
        t = {};
        for (int i = 1; i <= 8; i++) t.push_back(16'(i));
        run_op(t, 1, 5, 1'b1, 1'b1);

        // Reset after three accepted terms
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.product  = 16'h0123;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_sum", {16'b0, bus.sum}, 32'd0);
        check("midrst_overflow", {31'b0, bus.overflow}, 32'd0);
        check("midrst_busy", {31'b0, bus.busy}, 32'd0);
        t = {};
        repeat (8) t.push_back(16'h0002);
        run_op(t, 0, 0, 1'b0, 1'b0);

        // Randomized operations
        for (int n = 0; n < 8; n++) begin
            t = {};
            for (int i = 0; i < 8; i++) begin
                if (n[0]) t.push_back(16'($urandom));
                else      t.push_back(16'($signed(10'($urandom))));
            end
            run_op(t, 2, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        // Single-term instance
        @(posedge clk); #1 bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start    = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.product  = 16'h1234;
        @(negedge clk);
        check("n1_in_ready", {31'b0, bus1.in_ready}, 32'd1);
        @(posedge clk); #1 bus1.in_valid = 1'b0;
        @(negedge clk);
        check("n1_out_valid", {31'b0, bus1.out_valid}, 32'd1);
        check("n1_sum", {16'b0, bus1.sum}, 32'h1234);
        check("n1_overflow", {31'b0, bus1.overflow}, 32'd0);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1 bus1.out_ready = 1'b0;
        @(negedge clk);
        check("n1_idle", {31'b0, bus1.busy}, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
